// File: rtl/pwm_bank.sv
// N-channel PWM bank: byte register port, prescaler, double-buffered duty.
// Optional center-aligned mode via `define PWM_BANK_CENTER_ALIGN_EN.
module pwm_bank #(
  parameter int          CHANNELS    = 16,
  parameter logic [11:0] PRESC_RESET = 12'd0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [5:0]          wr_addr,
  input  logic [7:0]          wr_data,
  output logic [CHANNELS-1:0] out,
  output logic                period_start
);

  localparam int NB = CHANNELS / 8;

  logic [CHANNELS-1:0] r_out_en;
  logic [CHANNELS-1:0] r_pwm_en;
  logic [CHANNELS-1:0] r_out;
  logic [7:0]          r_pend [CHANNELS];
  logic [7:0]          r_act  [CHANNELS];
  logic [11:0]         r_presc;
  logic [11:0]         r_presc_cnt;
  logic [7:0]          r_cnt;
  logic                r_wrap;
  logic                r_ps;

  logic                w_tick;
  logic                w_presc_we;
  logic                w_wrap_pos;
  logic                w_wrap;
  logic [7:0]          w_cnt_step;
  logic [5:0]          w_didx;
  logic [CHANNELS-1:0] w_duty_we;
  logic [NB-1:0]       w_oen_we;
  logic [NB-1:0]       w_pen_we;
  logic [CHANNELS-1:0] w_pwm;

`ifdef PWM_BANK_CENTER_ALIGN_EN
  logic r_mode;
  logic r_mode_pend;
  logic r_down;
  logic w_down_nxt;
`endif

  always_comb begin
    w_tick     = (r_presc_cnt == r_presc);
    w_presc_we = wr_en && (wr_addr == 6'h08 || wr_addr == 6'h0A);
    w_didx     = wr_addr - 6'h10;
    w_duty_we  = '0;
    w_pwm      = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_duty_we[i] = wr_en && (wr_addr >= 6'h10) &&
                     (w_didx == 6'(i));
      w_pwm[i] = (r_act[i] == 8'hFF) | (r_cnt < r_act[i]);
    end
    w_oen_we = '0;
    w_pen_we = '0;
    for (int k = 0; k < NB; k++) begin
      w_oen_we[k] = wr_en && (wr_addr == 6'(k));
      w_pen_we[k] = wr_en && (wr_addr == 6'(4 + k));
    end
  end

  // Next counter value if this cycle ticks, and whether that is the wrap
  always_comb begin
    w_wrap_pos = (r_cnt == 8'd254);
    w_cnt_step = w_wrap_pos ? 8'd0 : r_cnt + 8'd1;
`ifdef PWM_BANK_CENTER_ALIGN_EN
    w_down_nxt = r_down;
    if (r_mode) begin
      w_wrap_pos = r_down && (r_cnt == 8'd1);
      if (r_down) begin
        w_cnt_step = r_cnt - 8'd1;
      end else if (r_cnt == 8'd254) begin
        w_cnt_step = 8'd253;
        w_down_nxt = 1'b1;
      end else begin
        w_cnt_step = r_cnt + 8'd1;
      end
    end
    if (w_wrap_pos) w_down_nxt = 1'b0;
`endif
    w_wrap = w_tick && w_wrap_pos;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_en    <= '0;
      r_pwm_en    <= '0;
      r_out       <= '0;
      r_presc     <= PRESC_RESET;
      r_presc_cnt <= '0;
      r_cnt       <= '0;
      r_wrap      <= 1'b0;
      r_ps        <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        r_pend[i] <= '0;
        r_act[i]  <= '0;
      end
`ifdef PWM_BANK_CENTER_ALIGN_EN
      r_mode      <= 1'b0;
      r_mode_pend <= 1'b0;
      r_down      <= 1'b0;
`endif
    end else begin
      if (wr_en && wr_addr == 6'h08) r_presc[7:0]  <= wr_data;
      if (wr_en && wr_addr == 6'h0A) r_presc[11:8] <= wr_data[3:0];
      r_presc_cnt <= (w_presc_we || w_tick) ? 12'd0
                                            : r_presc_cnt + 12'd1;
      if (w_tick) r_cnt <= w_cnt_step;
      for (int k = 0; k < NB; k++) begin
        if (w_oen_we[k]) r_out_en[8*k +: 8] <= wr_data;
        if (w_pen_we[k]) r_pwm_en[8*k +: 8] <= wr_data;
      end
      // A duty write landing on the wrap bypasses straight into active
      for (int i = 0; i < CHANNELS; i++) begin
        if (w_duty_we[i]) r_pend[i] <= wr_data;
        if (w_wrap) r_act[i] <= w_duty_we[i] ? wr_data : r_pend[i];
      end
      r_out  <= r_out_en & (~r_pwm_en | w_pwm);
      r_wrap <= w_wrap;
      r_ps   <= r_wrap;
`ifdef PWM_BANK_CENTER_ALIGN_EN
      if (wr_en && wr_addr == 6'h09) r_mode_pend <= wr_data[0];
      if (w_wrap) r_mode <= r_mode_pend;
      if (w_tick) r_down <= w_down_nxt;
`endif
    end
  end

  assign out          = r_out;
  assign period_start = r_ps;

endmodule
